// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, FSM encoding and the byte-wide CRC-32 step.
package eth_pkg;

  localparam logic [7:0]  ETH_PRE         = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;

  // One pending payload byte plus four bytes that may turn out to be the FCS.
  localparam int LINE_DEPTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  // CRC-32 (poly 04C11DB7) over one byte, bit 0 first as it appears on the wire.
  // The register is kept unreflected, so a clean frame leaves ETH_CRC_RESIDUE.
  function automatic logic [31:0] next_crc8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_gmii_rx_if.sv
// Payload byte stream leaving the GMII receive front end.
interface eth_gmii_rx_if;
  logic [7:0] dat;
  logic       valid;
  logic       sop;
  logic       eop;
  logic       err;

  modport master (output dat, valid, sop, eop, err);
  modport slave  (input  dat, valid, sop, eop, err);
endinterface

// File: rtl/eth_crc32_d8.sv
// Registered CRC-32 accumulator, one byte per enabled cycle; init wins over en.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;

  // CRC register: preset between frames, advance on each frame byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= ETH_CRC_INIT;
    end else if (init) begin
      crc_q <= ETH_CRC_INIT;
    end else if (en) begin
      crc_q <= next_crc8(din, crc_q);
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/eth_gmii_rx.sv
// GMII receive front end: strips preamble/SFD, checks and removes the FCS,
// and emits the payload as a registered byte stream with sop/eop/err.
//
//  state | meaning
//  IDLE  | between frames, waiting for rx_dv
//  PRE   | inside preamble (0x55 bytes), waiting for SFD
//  DATA  | after SFD, bytes go to CRC and the 5-byte line
//  DROP  | malformed start, discard until rx_dv falls
module eth_gmii_rx
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1514,
  parameter int MIN_LEN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_dat,
  input  logic             rx_dv,
  input  logic             rx_er,
  eth_gmii_rx_if.master    m,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  localparam int               LEN_W     = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [2:0]       LINE_FULL = 3'(LINE_DEPTH);

  rx_state_e        state_q, state_d;
  logic [7:0]       line_q [LINE_DEPTH];
  logic [2:0]       fill_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_last;
  logic             er_q;
  logic [31:0]      crc_val;
  logic             line_full;
  logic             frame_bad;

  logic             line_push;
  logic             line_clr;
  logic             crc_init;
  logic             crc_en;
  logic             emit;
  logic             emit_last;
  logic             bump_ok;
  logic             bump_err;

  logic [7:0]       dat_q;
  logic             valid_q;
  logic             sop_q;
  logic             eop_q;
  logic             err_q;

  eth_crc32_d8 u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (crc_init),
    .en      (crc_en),
    .din     (rx_dat),
    .crc_out (crc_val)
  );

  assign line_full = (fill_q == LINE_FULL);

  // Length including the byte about to leave as eop; stays pinned once past MAX_LEN.
  assign len_last  = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;

  assign frame_bad = (crc_val != ETH_CRC_RESIDUE) | er_q |
                     (len_last < LEN_MIN) | (len_last > LEN_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    state_d   = state_q;
    line_push = 1'b0;
    line_clr  = 1'b1;
    crc_init  = 1'b1;
    crc_en    = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    bump_ok   = 1'b0;
    bump_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_dv) begin
          if (rx_dat == ETH_PRE)      state_d = ST_PRE;
          else if (rx_dat == ETH_SFD) state_d = ST_DATA;
          else                        state_d = ST_DROP;
        end
      end
      ST_PRE: begin
        if (!rx_dv)                 state_d = ST_IDLE;
        else if (rx_dat == ETH_SFD) state_d = ST_DATA;
        else if (rx_dat != ETH_PRE) state_d = ST_DROP;
      end
      ST_DATA: begin
        if (rx_dv) begin
          line_clr  = 1'b0;
          crc_init  = 1'b0;
          line_push = 1'b1;
          crc_en    = 1'b1;
          emit      = line_full;
        end else begin
          state_d = ST_IDLE;
          if (line_full) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            bump_ok   = ~frame_bad;
            bump_err  = frame_bad;
          end else begin
            bump_err  = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!rx_dv) begin
          state_d  = ST_IDLE;
          bump_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte line, payload length and sticky rx_er for the frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      len_q  <= '0;
      er_q   <= 1'b0;
      for (int i = 0; i < LINE_DEPTH; i++) line_q[i] <= '0;
    end else if (line_clr) begin
      fill_q <= '0;
      len_q  <= '0;
      er_q   <= 1'b0;
    end else if (line_push) begin
      if (rx_er) er_q <= 1'b1;
      if (line_full) begin
        for (int i = 0; i < LINE_DEPTH - 1; i++) line_q[i] <= line_q[i+1];
        line_q[LINE_DEPTH-1] <= rx_dat;
        if (len_q != LEN_SAT) len_q <= len_q + 1'b1;
      end else begin
        line_q[fill_q] <= rx_dat;
        fill_q         <= fill_q + 3'd1;
      end
    end
  end

  // Registered output beat; the oldest line entry is the byte that leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dat_q   <= emit ? line_q[0] : 8'h00;
      valid_q <= emit;
      sop_q   <= emit & (len_q == '0);
      eop_q   <= emit_last;
      err_q   <= emit_last & frame_bad;
    end
  end

  // Frame statistics, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      if (bump_ok)  frame_ok_cnt  <= frame_ok_cnt + 1'b1;
      if (bump_err) frame_err_cnt <= frame_err_cnt + 1'b1;
    end
  end

  assign m.dat   = dat_q;
  assign m.valid = valid_q;
  assign m.sop   = sop_q;
  assign m.eop   = eop_q;
  assign m.err   = err_q;

endmodule

// File: tb/tb_eth_gmii_rx.sv
// Bench for eth_gmii_rx: directed and random frames against a frame-level model.
module tb_eth_gmii_rx;

  localparam int MAX_LEN = 1514;
  localparam int MIN_LEN = 1;
  localparam int CNT_W   = 16;

  typedef logic [7:0] bq_t [$];

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic [7:0]       rx_dat = 8'h00;
  logic             rx_dv  = 1'b0;
  logic             rx_er  = 1'b0;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] err_cnt;

  eth_gmii_rx_if rx_if ();

  eth_gmii_rx #(
    .MAX_LEN (MAX_LEN),
    .MIN_LEN (MIN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_dat        (rx_dat),
    .rx_dv         (rx_dv),
    .rx_er         (rx_er),
    .m             (rx_if),
    .frame_ok_cnt  (ok_cnt),
    .frame_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               errors  = 0;
  int               checks  = 0;
  logic [CNT_W-1:0] exp_ok  = '0;
  logic [CNT_W-1:0] exp_err = '0;
  int               first_cyc = 0;

  logic [7:0] b_dat [$];
  logic       b_sop [$];
  logic       b_eop [$];
  logic       b_err [$];
  int         b_cyc [$];
  int         stray = 0;

  // Output monitor, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (rx_if.valid === 1'b1) begin
      b_dat.push_back(rx_if.dat);
      b_sop.push_back(rx_if.sop);
      b_eop.push_back(rx_if.eop);
      b_err.push_back(rx_if.err);
      b_cyc.push_back(cyc);
    end else if (rx_if.sop !== 1'b0 || rx_if.eop !== 1'b0) begin
      stray++;
    end
  end

  // Standard reflected Ethernet CRC; the FCS is its complement, sent low byte first.
  function automatic logic [31:0] ref_fcs(input bq_t d, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t with_fcs(input bq_t pl);
    bq_t         r;
    logic [31:0] f;
    r = pl;
    f = ref_fcs(pl, pl.size());
    for (int k = 0; k < 4; k++) r.push_back(f[8*k +: 8]);
    return r;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t r;
    r = {};
    for (int i = 0; i < n; i++) r.push_back(8'($urandom_range(0, 255)));
    return r;
  endfunction

  // Expected payload and status for the bytes following SFD; updates expected counters.
  task automatic model_frame(input bq_t body, input int er_from,
                             output bq_t exp_pl, output logic exp_bad);
    int          n;
    logic [31:0] got;
    n      = body.size();
    exp_pl = {};
    if (n < 5) begin
      exp_bad = 1'b1;
      exp_err = exp_err + 1'b1;
      return;
    end
    for (int i = 0; i < n - 4; i++) exp_pl.push_back(body[i]);
    got     = {body[n-1], body[n-2], body[n-3], body[n-4]};
    exp_bad = (got !== ref_fcs(body, n - 4)) || (er_from >= 0 && er_from < n) ||
              (n - 4 < MIN_LEN) || (n - 4 > MAX_LEN);
    if (exp_bad) exp_err = exp_err + 1'b1;
    else         exp_ok  = exp_ok + 1'b1;
  endtask

  task automatic reset_pulse_check();
    checks++;
    assert (rx_if.valid === 1'b1)
      else begin errors++; $error("FAIL pre_reset_valid: got %b want 1", rx_if.valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert ({rx_if.dat, rx_if.valid, rx_if.sop, rx_if.eop, rx_if.err} === 12'h000 &&
            ok_cnt === '0 && err_cnt === '0)
      else begin
        errors++;
        $error("FAIL async_reset: got dat=%h v=%b s=%b e=%b r=%b ok=%0d err=%0d want all 0",
               rx_if.dat, rx_if.valid, rx_if.sop, rx_if.eop, rx_if.err, ok_cnt, err_cnt);
      end
    exp_ok  = '0;
    exp_err = '0;
    b_dat = {}; b_sop = {}; b_eop = {}; b_err = {}; b_cyc = {};
  endtask

  // Drives npre preamble bytes, a start byte, the body, then rx_dv low for gap cycles.
  task automatic run_frame(input int npre, input logic [7:0] sfd, input bq_t body,
                           input int er_from, input int gap, input int rst_idx);
    int n;
    n = body.size();
    for (int i = 0; i < npre + 1 + n; i++) begin
      @(negedge clk);
      if (rst_n === 1'b0) rst_n = 1'b1;
      rx_dv = 1'b1;
      if (i < npre) begin
        rx_dat = 8'h55;
        rx_er  = 1'b0;
      end else if (i == npre) begin
        rx_dat = sfd;
        rx_er  = 1'b0;
      end else begin
        rx_dat = body[i-npre-1];
        rx_er  = (er_from >= 0) && (i - npre - 1 >= er_from);
        if (i == npre + 1) first_cyc = cyc;
      end
      if (i == rst_idx) reset_pulse_check();
    end
    @(negedge clk);
    if (rst_n === 1'b0) rst_n = 1'b1;
    rx_dv  = 1'b0;
    rx_er  = 1'b0;
    rx_dat = 8'h00;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_beats(input string tag, input bq_t exp_pl, input logic exp_bad);
    int n, bad_dat, bad_flag;
    n        = exp_pl.size();
    bad_dat  = 0;
    bad_flag = 0;
    checks++;
    assert (b_dat.size() >= n)
      else begin errors++; $error("FAIL %s_beats: got %0d want %0d", tag, b_dat.size(), n); end
    if (n > 0 && b_dat.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        if (b_dat[i] !== exp_pl[i]) bad_dat++;
        if (b_sop[i] !== (i == 0)) bad_flag++;
        if (b_eop[i] !== (i == n - 1)) bad_flag++;
      end
      checks++;
      assert (bad_dat === 0)
        else begin errors++; $error("FAIL %s_data: got %0d wrong bytes want 0", tag, bad_dat); end
      checks++;
      assert (bad_flag === 0)
        else begin errors++; $error("FAIL %s_sop_eop: got %0d misplaced flags want 0", tag, bad_flag); end
      checks++;
      assert (b_err[n-1] === exp_bad)
        else begin errors++; $error("FAIL %s_err: got %b want %b", tag, b_err[n-1], exp_bad); end
      for (int i = 0; i < n; i++) begin
        void'(b_dat.pop_front());
        void'(b_sop.pop_front());
        void'(b_eop.pop_front());
        void'(b_err.pop_front());
        void'(b_cyc.pop_front());
      end
    end
  endtask

  task automatic check_empty(input string tag);
    checks++;
    assert (b_dat.size() === 0)
      else begin errors++; $error("FAIL %s_extra_beats: got %0d want 0", tag, b_dat.size()); end
    b_dat = {}; b_sop = {}; b_eop = {}; b_err = {}; b_cyc = {};
  endtask

  task automatic check_counters(input string tag);
    checks++;
    assert (ok_cnt === exp_ok)
      else begin errors++; $error("FAIL %s_ok_cnt: got %0d want %0d", tag, ok_cnt, exp_ok); end
    checks++;
    assert (err_cnt === exp_err)
      else begin errors++; $error("FAIL %s_err_cnt: got %0d want %0d", tag, err_cnt, exp_err); end
  endtask

  task automatic check_frame(input string tag, input bq_t exp_pl, input logic exp_bad);
    settle();
    check_beats(tag, exp_pl, exp_bad);
    check_empty(tag);
    check_counters(tag);
  endtask

  initial begin
    bq_t  pl, body, body2, exp_pl, exp_pl2;
    logic bad, bad2;
    int   kind, er_from, idx;

    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert ({rx_if.dat, rx_if.valid, rx_if.sop, rx_if.eop, rx_if.err} === 12'h000 &&
            ok_cnt === '0 && err_cnt === '0)
      else begin errors++; $error("FAIL reset_state: got v=%b ok=%0d err=%0d want 0", rx_if.valid, ok_cnt, err_cnt); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good 64-byte frame 0..63
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    body = with_fcs(pl);
    model_frame(body, -1, exp_pl, bad);
    run_frame(7, 8'hD5, body, -1, 4, -1);
    check_frame("good64", exp_pl, bad);

    // Same frame with rx_er from payload index 40
    model_frame(body, 40, exp_pl, bad);
    run_frame(7, 8'hD5, body, 40, 4, -1);
    check_frame("rx_er", exp_pl, bad);

    // Last FCS byte inverted; also first-beat latency
    body = with_fcs(pl);
    body[body.size()-1] = body[body.size()-1] ^ 8'hFF;
    model_frame(body, -1, exp_pl, bad);
    run_frame(7, 8'hD5, body, -1, 4, -1);
    settle();
    checks++;
    assert (b_cyc.size() > 0 && (b_cyc[0] - first_cyc - 1) === 5)
      else begin errors++; $error("FAIL latency: got %0d want 5", b_cyc.size() > 0 ? b_cyc[0] - first_cyc - 1 : -1); end
    check_beats("bad_fcs", exp_pl, bad);
    check_empty("bad_fcs");
    check_counters("bad_fcs");

    // Broken preamble -> dropped, then a good one-byte frame
    run_frame(3, 8'hAA, rand_bytes(10), -1, 4, -1);
    exp_err = exp_err + 1'b1;
    settle();
    check_empty("drop");
    check_counters("drop");
    body = with_fcs(rand_bytes(1));
    model_frame(body, -1, exp_pl, bad);
    run_frame(7, 8'hD5, body, -1, 4, -1);
    check_frame("one_byte", exp_pl, bad);

    // Random frames: short, good, corrupted, with and without rx_er
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        body = rand_bytes($urandom_range(0, 4));
      end else begin
        body = with_fcs(rand_bytes($urandom_range(1, 48)));
        if (kind == 3) begin
          idx = $urandom_range(0, body.size() - 1);
          body[idx] = body[idx] ^ 8'($urandom_range(1, 255));
        end
      end
      er_from = (body.size() > 0 && $urandom_range(0, 3) == 0) ?
                $urandom_range(0, body.size() - 1) : -1;
      model_frame(body, er_from, exp_pl, bad);
      run_frame($urandom_range(0, 7), 8'hD5, body, er_from, $urandom_range(1, 3), -1);
      check_frame("random", exp_pl, bad);
    end

    // Back-to-back 1 and 1600 bytes with one idle cycle between
    body  = with_fcs(rand_bytes(1));
    body2 = with_fcs(rand_bytes(1600));
    model_frame(body, -1, exp_pl, bad);
    model_frame(body2, -1, exp_pl2, bad2);
    run_frame(7, 8'hD5, body, -1, 1, -1);
    run_frame(7, 8'hD5, body2, -1, 4, -1);
    settle();
    check_beats("b2b_first", exp_pl, bad);
    check_beats("b2b_long", exp_pl2, bad2);
    check_empty("b2b");
    check_counters("b2b");

    // Length boundary: exactly MAX_LEN, then one more
    body = with_fcs(rand_bytes(MAX_LEN));
    model_frame(body, -1, exp_pl, bad);
    run_frame(7, 8'hD5, body, -1, 2, -1);
    check_frame("max_len", exp_pl, bad);
    body = with_fcs(rand_bytes(MAX_LEN + 1));
    model_frame(body, -1, exp_pl, bad);
    run_frame(7, 8'hD5, body, -1, 2, -1);
    check_frame("max_len_plus1", exp_pl, bad);

    // Reset pulse in the middle of DATA, then a clean frame
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    body = with_fcs(pl);
    run_frame(7, 8'hD5, body, -1, 4, 7 + 1 + 20);
    exp_err = exp_err + 1'b1;
    settle();
    check_empty("mid_reset");
    check_counters("mid_reset");
    body = with_fcs(rand_bytes(20));
    model_frame(body, -1, exp_pl, bad);
    run_frame(7, 8'hD5, body, -1, 4, -1);
    check_frame("after_reset", exp_pl, bad);

    checks++;
    assert (stray === 0)
      else begin errors++; $error("FAIL stray_flags: got %0d want 0", stray); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
